// File: rtl/aixh_mxc_upper_bwd_collector.sv
// aixh_mxc_upper_bwd_collector
// Terminal stage of the MxConv upper backward chain. Consecutive backward
// beats are packed PACK at a time into one wide word (first beat in the LSB
// lane). Packed words are queued in a DEPTH-entry FIFO and drained through a
// valid/ready port. The backward chain cannot be stalled, so an almost-full
// hint is exported.
// Optional feature macro: AIXH_MXC_UPPER_BWD_COLLECT_OVF_EN enables the sticky
// overflow flag o_ovf. When it is undefined, o_ovf is tied low and i_ovf_clr
// is ignored.

`ifndef UPCELL_BWD_DWIDTH
`define UPCELL_BWD_DWIDTH 32
`endif

module aixh_mxc_upper_bwd_collector #(
    parameter int DWIDTH   = `UPCELL_BWD_DWIDTH,
    parameter int PACK     = 2,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                         aixh_core_clk2x,
    input  logic                         aixh_core_rstn,
    input  logic                         i_bwd_vld,
    input  logic [DWIDTH-1:0]            i_bwd_dat,
    input  logic                         i_flush,
    output logic                         o_vld,
    output logic [PACK*DWIDTH-1:0]       o_dat,
    input  logic                         i_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
    output logic                         o_afull,
    output logic                         o_ovf,
    input  logic                         i_ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WW = PACK * DWIDTH;

    logic [PW-1:0] pidx_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] push_word;

    logic pack_done;
    logic push_req;
    logic pop;
    logic push_acc;

    // The beat arriving in the last lane completes the word.
    assign pack_done = (pidx_reg == PW'(PACK - 1));
    assign push_req  = i_bwd_vld && pack_done;
    assign pop       = (cnt_reg != '0) && i_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    assign push_acc  = push_req && ((cnt_reg < CW'(DEPTH)) || pop);

    // Pack index: advance per valid beat, wrap after the last lane, clear on flush.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            pidx_reg <= '0;
        end else if (i_flush) begin
            pidx_reg <= '0;
        end else if (i_bwd_vld) begin
            pidx_reg <= pack_done ? '0 : pidx_reg + PW'(1);
        end
    end

    // Lanes 0..PACK-2 are held in registers; the last lane comes straight
    // from the completing beat so the word can be pushed in that same cycle.
    generate
        for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
            if (gi < PACK - 1) begin : g_stored
                logic [DWIDTH-1:0] lane_reg;

                // Capture the beat addressed to this lane (data only, no reset needed).
                always_ff @(posedge aixh_core_clk2x) begin
                    if (i_bwd_vld && (pidx_reg == PW'(gi))) begin
                        lane_reg <= i_bwd_dat;
                    end
                end

                assign push_word[gi*DWIDTH +: DWIDTH] = lane_reg;
            end else begin : g_live
                assign push_word[gi*DWIDTH +: DWIDTH] = i_bwd_dat;
            end
        end
    endgenerate

    // FIFO storage write; contents are intentionally not reset.
    always_ff @(posedge aixh_core_clk2x) begin
        if (push_acc && !i_flush) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    // Pointers and occupancy counter; flush returns everything to empty.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_acc && !pop) begin
                cnt_reg <= cnt_reg + CW'(1);
            end else if (!push_acc && pop) begin
                cnt_reg <= cnt_reg - CW'(1);
            end
        end
    end

    // Outputs depend only on registered state, never on i_rdy directly.
    assign o_vld   = (cnt_reg != '0);
    assign o_dat   = mem[rd_ptr_reg];
    assign o_cnt   = cnt_reg;
    assign o_afull = (cnt_reg >= CW'(AFULL_TH));

`ifdef AIXH_MXC_UPPER_BWD_COLLECT_OVF_EN
    logic ovf_reg;

    // Sticky overflow: set by a dropped word, cleared by i_ovf_clr; set wins.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            ovf_reg <= 1'b0;
        end else if (push_req && !push_acc && !i_flush) begin
            ovf_reg <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign o_ovf = ovf_reg;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = i_ovf_clr;
    assign o_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_aixh_mxc_upper_bwd_collector.sv
// Testbench for aixh_mxc_upper_bwd_collector (DWIDTH=8, PACK=2, DEPTH=4,
// AFULL_TH=2). Table-driven directed scenarios, an asynchronous reset
// sequence, then randomized traffic against a queue-based reference model.
// Overflow expectations follow AIXH_MXC_UPPER_BWD_COLLECT_OVF_EN.

module tb_aixh_mxc_upper_bwd_collector;

    localparam int DW = 8;
    localparam int PK = 2;
    localparam int DP = 4;
    localparam int TH = 2;

`ifdef AIXH_MXC_UPPER_BWD_COLLECT_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rstn  = 1'b0;
    logic              vld   = 1'b0;
    logic [DW-1:0]     dat   = '0;
    logic              flush = 1'b0;
    logic              rdy   = 1'b0;
    logic              clr   = 1'b0;
    logic              o_vld;
    logic [PK*DW-1:0]  o_dat;
    logic [2:0]        o_cnt;
    logic              o_afull;
    logic              o_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: queued words, beats of the partial word, flag.
    logic [PK*DW-1:0] mq[$];
    logic [DW-1:0]    mpart[$];
    bit               movf = 1'b0;

    typedef struct {
        bit               v;
        logic [DW-1:0]    d;
        bit               f;
        bit               r;
        bit               c;
        bit               ev;
        int               ec;
        bit               ea;
        bit               eo;
        logic [PK*DW-1:0] ed;
    } vec_t;

    vec_t tbl[$];

    aixh_mxc_upper_bwd_collector #(
        .DWIDTH  (DW),
        .PACK    (PK),
        .DEPTH   (DP),
        .AFULL_TH(TH)
    ) dut (
        .aixh_core_clk2x(clk),
        .aixh_core_rstn (rstn),
        .i_bwd_vld      (vld),
        .i_bwd_dat      (dat),
        .i_flush        (flush),
        .o_vld          (o_vld),
        .o_dat          (o_dat),
        .i_rdy          (rdy),
        .o_cnt          (o_cnt),
        .o_afull        (o_afull),
        .o_ovf          (o_ovf),
        .i_ovf_clr      (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: words leave in arrival order; a completed word
    // is kept only if there is room once this cycle's pop has happened.
    task automatic model_step(input bit v, input logic [DW-1:0] d, input bit f,
                              input bit r, input bit c);
        bit set;
        logic [PK*DW-1:0] w;
        set = 1'b0;
        if (f) begin
            mq.delete();
            mpart.delete();
        end else begin
            if (mq.size() != 0 && r) void'(mq.pop_front());
            if (v) begin
                mpart.push_back(d);
                if (mpart.size() == PK) begin
                    for (int k = 0; k < PK; k++) w[k*DW +: DW] = mpart[k];
                    if (mq.size() < DP) mq.push_back(w);
                    else set = 1'b1;
                    mpart.delete();
                end
            end
        end
        if (OVF_ON) begin
            if (set) movf = 1'b1;
            else if (c) movf = 1'b0;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpart.delete();
        movf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " vld"},   32'(o_vld),   32'(mq.size() != 0));
        check({tag, " cnt"},   32'(o_cnt),   32'(mq.size()));
        check({tag, " afull"}, 32'(o_afull), 32'(mq.size() >= TH));
        check({tag, " ovf"},   32'(o_ovf),   32'(movf));
        if (mq.size() != 0) check({tag, " dat"}, 32'(o_dat), 32'(mq[0]));
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic apply(input bit v, input logic [DW-1:0] d, input bit f,
                         input bit r, input bit c);
        vld = v; dat = d; flush = f; rdy = r; clr = c;
        @(posedge clk);
        #1;
        model_step(v, d, f, r, c);
        $display("[TB] cyc v=%0b d=%02h f=%0b r=%0b c=%0b -> vld=%0b cnt=%0d dat=%04h ovf=%0b",
                 v, d, f, r, c, o_vld, o_cnt, o_dat, o_ovf);
    endtask

    task automatic add(input bit v, input logic [DW-1:0] d, input bit f, input bit r,
                       input bit c, input bit ev, input int ec, input bit ea,
                       input bit eo, input logic [PK*DW-1:0] ed);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r; t.c = c;
        t.ev = ev; t.ec = ec; t.ea = ea; t.eo = eo; t.ed = ed;
        tbl.push_back(t);
    endtask

    initial begin
        // Packing: one word, visible for exactly one cycle.
        add(1, 8'h11, 0, 1, 0,  0, 0, 0, 0, 16'h0000);
        add(1, 8'h22, 0, 1, 0,  1, 1, 0, 0, 16'h2211);
        add(0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 16'h0000);
        // Fill with no consumer; afull at two words.
        add(1, 8'h01, 0, 0, 0,  0, 0, 0, 0, 16'h0000);
        add(1, 8'h02, 0, 0, 0,  1, 1, 0, 0, 16'h0201);
        add(1, 8'h03, 0, 0, 0,  1, 1, 0, 0, 16'h0201);
        add(1, 8'h04, 0, 0, 0,  1, 2, 1, 0, 16'h0201);
        add(1, 8'h05, 0, 0, 0,  1, 2, 1, 0, 16'h0201);
        add(1, 8'h06, 0, 0, 0,  1, 3, 1, 0, 16'h0201);
        add(1, 8'h07, 0, 0, 0,  1, 3, 1, 0, 16'h0201);
        add(1, 8'h08, 0, 0, 0,  1, 4, 1, 0, 16'h0201);
        // Overflow: 0xBBAA dropped, flag follows build option, then cleared.
        add(1, 8'hAA, 0, 0, 0,  1, 4, 1, 0, 16'h0201);
        add(1, 8'hBB, 0, 0, 0,  1, 4, 1, OVF_ON, 16'h0201);
        add(0, 8'h00, 0, 0, 1,  1, 4, 1, 0, 16'h0201);
        // Push and pop together at full.
        add(1, 8'hCC, 0, 0, 0,  1, 4, 1, 0, 16'h0201);
        add(1, 8'hDD, 0, 1, 0,  1, 4, 1, 0, 16'h0403);
        add(0, 8'h00, 0, 1, 0,  1, 3, 1, 0, 16'h0605);
        add(0, 8'h00, 0, 1, 0,  1, 2, 1, 0, 16'h0807);
        add(0, 8'h00, 0, 1, 0,  1, 1, 0, 0, 16'hDDCC);
        add(0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 16'h0000);
        // Flush mid-pack: only 0x6655 survives.
        add(1, 8'h33, 0, 1, 0,  0, 0, 0, 0, 16'h0000);
        add(1, 8'h44, 1, 1, 0,  0, 0, 0, 0, 16'h0000);
        add(1, 8'h55, 0, 1, 0,  0, 0, 0, 0, 16'h0000);
        add(1, 8'h66, 0, 1, 0,  1, 1, 0, 0, 16'h6655);
        add(0, 8'h00, 0, 1, 0,  0, 0, 0, 0, 16'h0000);

        // Reset state.
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check("reset vld",   32'(o_vld),   32'd0);
        check("reset cnt",   32'(o_cnt),   32'd0);
        check("reset afull", 32'(o_afull), 32'd0);
        check("reset ovf",   32'(o_ovf),   32'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r, tbl[i].c);
            check($sformatf("row%0d vld", i),   32'(o_vld),   32'(tbl[i].ev));
            check($sformatf("row%0d cnt", i),   32'(o_cnt),   32'(tbl[i].ec));
            check($sformatf("row%0d afull", i), 32'(o_afull), 32'(tbl[i].ea));
            check($sformatf("row%0d ovf", i),   32'(o_ovf),   32'(tbl[i].eo));
            if (tbl[i].ev) check($sformatf("row%0d dat", i), 32'(o_dat), 32'(tbl[i].ed));
            check_model($sformatf("row%0d model", i));
        end

        // Asynchronous reset mid-drain: three words queued, reset between edges.
        for (int k = 0; k < 6; k++) apply(1, 8'h10 + 8'(k), 0, 0, 0);
        check("pre-reset cnt", 32'(o_cnt), 32'd3);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("async vld", 32'(o_vld), 32'd0);
        check("async cnt", 32'(o_cnt), 32'd0);
        vld = 1'b0; flush = 1'b0; rdy = 1'b0; clr = 1'b0;
        #3 rstn = 1'b1;
        apply(1, 8'h77, 0, 0, 0);
        apply(1, 8'h88, 0, 0, 0);
        check("post-reset vld", 32'(o_vld), 32'd1);
        check("post-reset dat", 32'(o_dat), 32'h8877);
        check_model("post-reset model");
        apply(0, 8'h00, 0, 1, 0);
        check("post-reset drain", 32'(o_cnt), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aixh_mxc_upper_bwd_collector.md
# aixh_mxc_upper_bwd_collector

Terminal stage of the MxConv upper backward chain: consumes the registered `o_bwd_vld`/`o_bwd_dat` stream from the last upper repeater. It packs `PACK` consecutive beats into one wide word and buffers packed words in a `DEPTH`-entry FIFO. Words leave through a valid/ready port to the result writer. The backward chain has no backpressure, so the block exports an almost-full hint to the forward-command issuer and, optionally, a sticky overflow flag.

## Interface
- `DWIDTH`, default `UPCELL_BWD_DWIDTH`: width of one backward beat.
- `PACK`, default 2: beats per output word; legal range 1..8.
- `DEPTH`, default 8: FIFO depth in packed words; power of two, 2 or more.
- `AFULL_TH`, default `DEPTH-2`: occupancy at which `o_afull` asserts.
- `aixh_core_clk2x`, in, 1: the block's only clock.
- `aixh_core_rstn`, in, 1: reset, asynchronous assert, active-low.
- `i_bwd_vld`, in, 1: backward beat valid, driven by the repeater.
- `i_bwd_dat`, in, `DWIDTH`: backward beat data.
- `i_flush`, in, 1: synchronous discard of the partial pack and all FIFO contents.
- `o_vld`, out, 1: FIFO head valid.
- `o_dat`, out, `PACK*DWIDTH`: FIFO head word.
- `i_rdy`, in, 1: consumer accepts the head word.
- `o_cnt`, out, `$clog2(DEPTH+1)`: FIFO occupancy in words.
- `o_afull`, out, 1: `o_cnt >= AFULL_TH`.
- `o_ovf`, out, 1: sticky overflow flag (see Configuration).
- `i_ovf_clr`, in, 1: clears `o_ovf`.

## Operation
- Pack index `pidx` counts 0..PACK-1. Each valid beat is written to lane `pidx`, bits `[pidx*DWIDTH +: DWIDTH]`, so the first beat lands in the LSB lane.
- Beat with `pidx == PACK-1`:
  - The full word (stored lanes plus the current beat, merged combinationally) is pushed into the FIFO.
  - `pidx` returns to 0.
- `PACK == 1`: every beat is pushed directly and `pidx` is constant 0.
- Pop: `o_vld && i_rdy`. `o_vld = (o_cnt != 0)`. `o_dat` is the entry at the read pointer and is held stable while `o_vld && !i_rdy`.
- Push acceptance: accepted when `o_cnt < DEPTH` or a pop occurs in the same cycle. A simultaneous push and pop at full leaves `o_cnt` at DEPTH.
- Rejected push:
  - The word is dropped and the pointers are unchanged.
  - `pidx` still returns to 0, so alignment is preserved.
- Pointers are `log2(DEPTH)` bits and wrap naturally. Occupancy is tracked by an explicit counter, never by pointer comparison.
- Flush has priority over everything:
  - Next cycle: `pidx = 0`, `o_cnt = 0`, both pointers 0.
  - A beat or pop presented in the flush cycle is discarded/ignored.
  - `o_ovf` is not affected.
- `o_afull` is decoded from the registered count, so it carries no combinational path from inputs.

## Timing
- Reset values: `o_vld = 0`, `o_cnt = 0`, `o_afull = 0` (when `AFULL_TH > 0`), `o_ovf = 0`, `pidx = 0`, pointers 0. `o_dat` is don't-care until first written; FIFO storage is not reset.
- Latency: completing beat in cycle N gives `o_vld = 1` with that word in cycle N+1, provided the FIFO was empty.
- Throughput: one beat per cycle in; one word per cycle out.
- `o_cnt` and `o_afull` update the cycle after the push or pop.
- No combinational path from `i_rdy` to `o_vld` or `o_dat`.
- Reset asserted mid-pack or mid-drain returns the block to reset values immediately. Partial data is lost.

## Configuration
- `AIXH_MXC_UPPER_BWD_COLLECT_OVF_EN` defined:
  - A rejected push sets `o_ovf` in cycle N+1.
  - `o_ovf` stays set until `i_ovf_clr`, which takes effect next cycle.
  - If set and clear coincide, set wins.
- Not defined: `o_ovf` is tied to 0, `i_ovf_clr` is ignored, and rejected words are dropped silently. There is no overflow logic.

## Test plan
All scenarios use DWIDTH=8, PACK=2, DEPTH=4, AFULL_TH=2.
- Packing: beats 0x11 then 0x22 on back-to-back cycles, `i_rdy = 1`. Required: `o_vld` for exactly one cycle, `o_dat = 0x2211`, one cycle after the 0x22 beat.
- Fill and afull: 8 beats 0x01..0x08 with `i_rdy = 0`.
  - `o_cnt` steps 1, 2, 3, 4.
  - `o_afull` rises the cycle `o_cnt` reaches 2.
  - Draining gives 0x0201, 0x0403, 0x0605, 0x0807 in order.
- Overflow, macro on: FIFO full, `i_rdy = 0`, two more beats 0xAA, 0xBB.
  - Word 0xBBAA is dropped and `o_ovf = 1` next cycle; contents are unchanged.
  - `i_ovf_clr` makes `o_ovf = 0` next cycle.
  - Rebuilt with the macro off: `o_ovf` stays 0.
- Push/pop at full: FIFO full with `i_rdy = 1` while pair 0xCC, 0xDD completes.
  - `o_cnt` stays 4.
  - Head advances, and 0xDDCC emerges fourth.
- Flush mid-pack: beat 0x33, then flush together with beat 0x44, then beats 0x55, 0x66. Required: only word 0x6655 appears.
- Async reset mid-drain: FIFO holding 3 words, `aixh_core_rstn` low between clock edges.
  - `o_vld = 0` and `o_cnt = 0` immediately, without waiting for a clock edge.
  - After release, beats 0x77, 0x88 give 0x8877.
